vector_reversal_arbiter: RTL
============================

// Module: vector_reversal_arbiter
// PURPOSE
//  Shares one bit-reversal datapath among NUM_REQ requesters using round-robin arbitration.
//  Each accepted word is bit-reversed (out[i] = in[WIDTH-1-i]) into a single output register.
//  The output register drives a valid/ready stream, tagged with the requester index.
//  Sits between several producer streams and one consumer of reversed vectors.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..16)
//  WIDTH    8  data width of each word, in bits (>=1)
//  IDW      $clog2(NUM_REQ)  width of the requester-index tag (derived, not overridable)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            synchronous, active-high reset
//  req_valid  in   NUM_REQ      per-requester valid
//  req_data   in   NUM_REQ*WIDTH  requester r occupies bits [r*WIDTH +: WIDTH]
//  req_ready  out  NUM_REQ      one-hot or zero; high = word accepted this cycle
//  out_valid  out  1            output register holds a reversed word
//  out_data   out  WIDTH        reversed word
//  out_id     out  IDW          index of the requester that supplied out_data
//  out_ready  in   1            consumer accepts when out_valid && out_ready
//  busy       out  1            out_valid || |req_valid
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_id=0, rr pointer=0, state=EMPTY.
//  - FSM with 2 states:
//    EMPTY (out_valid=0)
//      - any req_valid -> accept -> FULL
//      - otherwise stay in EMPTY
//    FULL (out_valid=1)
//      - out_ready && any req_valid -> accept, stay in FULL (back-to-back transfer)
//      - out_ready && no req_valid -> EMPTY
//      - !out_ready -> hold out_data/out_id stable and stay in FULL
//  - can_accept = !out_valid || out_ready.
//  - Grant g = first r with req_valid[r], searching ptr, ptr+1, ... with wrap mod NUM_REQ.
//  - req_ready is combinational:
//    - req_ready[g] = can_accept && |req_valid
//    - all other bits are 0
//    - req_ready never depends on req_data
//  - On accept, at the next edge:
//    - out_data <= reverse(req_data[g])
//    - out_id <= g
//    - out_valid <= 1
//    - ptr <= (g == NUM_REQ-1) ? 0 : g+1
//  - Latency is 1 cycle from accept to out_valid. Throughput is 1 word/cycle while out_ready=1.
//  - ptr changes only on accept. An idle cycle does not move the pointer.
//  - A requester that drops valid without ready loses nothing (no transfer occurred).
//  - Simultaneous drain and accept in FULL: the new word replaces the old one with no bubble.
//  - Reset asserted mid-operation:
//    - the held word is discarded
//    - all outputs return to reset values on the next edge
//    - req_ready=0 while reset=1
// CONFIGURATION
//  - Macro VREV_PARITY_EN:
//    - when defined, adds port out_parity (out, 1) = ^out_data.
//    - out_parity is registered alongside out_data and resets to 0.
//  - Without the macro, the port does not exist and no parity logic is built.
// STRUCTURE
//  - Package vrev_pkg:
//    - state enum {EMPTY, FULL}
//    - function rr_pick(valid, ptr) returning the grant index
//    - localparam helper for IDW
//  - Sub-module vrev_bits (combinational, parameter WIDTH):
//    - generate loop with out[i] = in[WIDTH-1-i]
//    - instantiated once after the grant mux
// TESTING
//  1. Single word:
//     - stimulus: req 0 valid, data 8'h01, out_ready=1
//     - response: next cycle out_valid=1, out_data=8'h80, out_id=0
//  2. Round robin:
//     - stimulus: all 4 requests valid continuously, out_ready=1
//     - response: out_id sequence 0,1,2,3,0 on consecutive cycles
//  3. Backpressure:
//     - stimulus: req 2 sends 8'hA5, out_ready=0 for 3 cycles
//     - response: out_data=8'hA5 and out_id=2 held; req_ready=0 for all; then handshake
//  4. Skip idle requesters:
//     - stimulus: ptr=1, only req 3 valid with 8'h0F
//     - response: grant 3, out_data=8'hF0, ptr becomes 0
//  5. Reset mid-operation:
//     - stimulus: FULL with out_ready=0, then assert reset for 1 cycle
//     - response: out_valid=0, out_data=0, ptr=0; next grant goes to lowest valid index
//  6. VREV_PARITY_EN:
//     - stimulus: data 8'h07
//     - response: out_data=8'hE0, out_parity=1

Source files
------------

// File: rtl/vrev_pkg.sv
// Shared types and helpers for the vector reversal arbiter: FSM state,
// round-robin grant search and tag-width helper.
package vrev_pkg;

   localparam int MAX_REQ = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } vrev_state_t;

   // Tag width for n requesters; never narrower than one bit.
   function automatic int idw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First valid index at or after ptr, wrapping modulo num. Walks offsets
   // from the far end back toward ptr so the nearest valid one wins.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                  input int ptr,
                                  input int num);
      int g;
      int idx;
      g = ptr;
      for (int k = num - 1; k >= 0; k--) begin
         idx = (ptr + k) % num;
         if (valid[idx[3:0]]) g = idx;
      end
      return g;
   endfunction

endpackage

// File: rtl/vrev_bits.sv
// Combinational bit reversal: dout[i] = din[WIDTH-1-i].
module vrev_bits #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign dout[i] = din[WIDTH-1-i];
   end

endmodule

// File: rtl/vector_reversal_arbiter.sv
// Round-robin arbiter feeding one bit-reversal datapath into a registered
// valid/ready output. Define VREV_PARITY_EN to add the registered out_parity port.
//
// state | meaning
// EMPTY | output register holds nothing, out_valid=0
// FULL  | output register holds a reversed word, out_valid=1
import vrev_pkg::*;

module vector_reversal_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   localparam int IDW    = idw_of(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [IDW-1:0]           out_id,
`ifdef VREV_PARITY_EN
   output logic                     out_parity,
`endif
   input  logic                     out_ready,
   output logic                     busy
);

   vrev_state_t state_q, state_d;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     grant;
   logic [MAX_REQ-1:0] valid_ext;
   logic [WIDTH-1:0]   data_sel;
   logic [WIDTH-1:0]   data_rev;
   logic               any_valid;
   logic               can_accept;
   logic               accept;

   assign any_valid  = |req_valid;
   assign out_valid  = (state_q == FULL);
   assign can_accept = !out_valid || out_ready;
   assign accept     = can_accept && any_valid && !reset;
   assign busy       = out_valid || any_valid;

   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_REQ-1:0] = req_valid;
      grant = IDW'(rr_pick(valid_ext, int'(ptr_q), NUM_REQ));
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   assign data_sel = req_data[grant*WIDTH +: WIDTH];

   vrev_bits #(.WIDTH(WIDTH)) u_bits (
      .din  (data_sel),
      .dout (data_rev)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (any_valid) state_d = FULL;
         FULL:  if (out_ready && !any_valid) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   // Output register and pointer only move on an accepted word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data <= '0;
         out_id   <= '0;
         ptr_q    <= '0;
      end else if (accept) begin
         out_data <= data_rev;
         out_id   <= grant;
         ptr_q    <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
   end

`ifdef VREV_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset)       out_parity <= 1'b0;
      else if (accept) out_parity <= ^data_rev;
   end
`endif

endmodule
